// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch state machine encoding (FETCH_RUN, FETCH_HALT)
//   fetch_entry_t : one buffered {pc, instr} pair handed to decode
//   INSTR_W, XLEN : instruction and address widths
//   HALT_WORD     : instruction word that stops fetching
//   PC_STEP       : byte increment between sequential instructions
package ifetch_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 32;

    localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;
    localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: bundles the fetch stage's memory port, decode handshake,
// redirect input and status outputs. Signal names keep the fetch stage's
// point of view (o_ = driven by fetch, i_ = driven by the environment).
//   master : used by ifetch
//   slave  : used by the surrounding pipeline / memory model
interface ifetch_if;
    import ifetch_pkg::*;

    logic [XLEN-1:0]    o_imem_addr;
    logic [INSTR_W-1:0] i_imem_data;
    logic               o_valid;
    logic               i_ready;
    logic [INSTR_W-1:0] o_instr;
    logic [XLEN-1:0]    o_pc;
    logic               i_redirect;
    logic [XLEN-1:0]    i_redirect_pc;
    logic               o_halted;
    logic               o_misaligned;

    modport master (
        output o_imem_addr, o_valid, o_instr, o_pc, o_halted, o_misaligned,
        input  i_imem_data, i_ready, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_imem_addr, o_valid, o_instr, o_pc, o_halted, o_misaligned,
        output i_imem_data, i_ready, i_redirect, i_redirect_pc
    );

endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: 2-entry synchronous FIFO of {pc, instr} pairs.
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_push/i_data  : write an entry (caller guarantees space)
//   i_pop          : drop the head (caller guarantees non-empty)
//   i_clear        : flush all entries; overrides push and pop
//   o_head         : head entry, all zeros when empty
//   o_count        : number of stored entries (0..2)
module ifetch_fifo
    import ifetch_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    // Storage and pointers. Clear wins over push/pop so a redirect never
    // leaves a stale entry behind.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (i_clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (i_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (i_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_head  = (count != 2'd0) ? mem[rd_ptr] : '0;
    assign o_count = count;

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage. Holds the pc, reads the combinational
// instruction memory every cycle, buffers {pc, instr} pairs in a 2-entry
// FIFO and hands them to decode over valid/ready. Redirects from execute
// flush the buffer and reload the pc; an all-zero word halts fetching.
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   bus            : ifetch_if.master (imem port, decode handshake,
//                    redirect, o_halted, o_misaligned)
//   RESET_PC       : pc loaded at reset (bits [1:0] must be 0)
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN -- a misaligned redirect
// target halts fetch and raises o_misaligned instead of being aligned down.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    ifetch_if.master  bus
);

    fetch_state_t state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;

    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic [1:0]   count;
    logic         valid;
    logic         pop;
    logic         has_space;
    logic         fetch;
    logic         push;

    assign valid = (count != 2'd0);
    assign pop   = valid && bus.i_ready;

    // A full buffer still has room when the head leaves this same cycle.
    assign has_space  = (count != 2'd2) || pop;
    assign fetch      = (state_q == FETCH_RUN) && !bus.i_redirect && has_space;
    assign push       = fetch && (bus.i_imem_data != HALT_WORD);
    assign push_entry = '{pc: pc_q, instr: bus.i_imem_data};

    ifetch_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_clear (bus.i_redirect),
        .i_data  (push_entry),
        .o_head  (head),
        .o_count (count)
    );

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;
    logic redirect_misaligned;

    assign redirect_misaligned = (bus.i_redirect_pc[1:0] != 2'b00);

    // Next-state logic with the misalignment trap: a redirect always loads
    // the raw target, and halts if it is not word aligned.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        if (bus.i_redirect) begin
            pc_d         = bus.i_redirect_pc;
            misaligned_d = redirect_misaligned;
            state_d      = redirect_misaligned ? FETCH_HALT : FETCH_RUN;
        end else if (fetch) begin
            if (push) begin
                pc_d = pc_q + PC_STEP;
            end else begin
                state_d = FETCH_HALT;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.o_misaligned = misaligned_q;
`else
    // Next-state logic without the trap: redirect targets are forced onto a
    // word boundary and fetch always resumes.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.i_redirect) begin
            pc_d    = {bus.i_redirect_pc[XLEN-1:2], 2'b00};
            state_d = FETCH_RUN;
        end else if (fetch) begin
            if (push) begin
                pc_d = pc_q + PC_STEP;
            end else begin
                state_d = FETCH_HALT;
            end
        end
    end

    assign bus.o_misaligned = 1'b0;
`endif

    // State and pc registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= FETCH_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.o_imem_addr = {2'b00, pc_q[XLEN-1:2]};
    assign bus.o_valid     = valid;
    assign bus.o_instr     = head.instr;
    assign bus.o_pc        = head.pc;
    assign bus.o_halted    = (state_q == FETCH_HALT);

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch. A 64-word instruction memory
// is indexed by the low bits of o_imem_addr. A queue-based reference model
// tracks what decode should see; directed steps follow the test plan and
// are followed by a randomized run.
module tb_ifetch;
    import ifetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ifetch_if bus ();

    ifetch #(.RESET_PC(RESET_PC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    logic [31:0] mem [64];
    assign bus.i_imem_data = mem[bus.o_imem_addr[5:0]];

    // Reference model: the buffer is a plain queue of {pc, instr} pairs.
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_mis;
    logic [63:0] m_q[$];
    logic [31:0] delivered[$];

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_halted = 1'b0;
        m_mis    = 1'b0;
        m_q.delete();
    endtask

    // Compare every output against the model's current state.
    task automatic check_state(input string where);
        logic [63:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 64'h0;
        check_output({where, " valid"}, {31'b0, bus.o_valid}, {31'b0, m_q.size() != 0});
        check_output({where, " pc"}, bus.o_pc, head[63:32]);
        check_output({where, " instr"}, bus.o_instr, head[31:0]);
        check_output({where, " addr"}, bus.o_imem_addr, m_pc >> 2);
        check_output({where, " halted"}, {31'b0, bus.o_halted}, {31'b0, m_halted});
        check_output({where, " misaligned"}, {31'b0, bus.o_misaligned}, {31'b0, m_mis});
    endtask

    // Model of one clock: redirect first, else pop then fetch if room.
    task automatic model_step(input logic ready, input logic redir, input logic [31:0] rpc);
        logic [31:0] w;
        if (redir) begin
            if (m_q.size() != 0 && ready) delivered.push_back(m_q[0][63:32]);
            m_q.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
            m_pc     = rpc;
            m_mis    = (rpc[1:0] != 2'b00);
            m_halted = m_mis;
`else
            m_pc     = rpc & 32'hFFFF_FFFC;
            m_halted = 1'b0;
`endif
        end else begin
            if (m_q.size() != 0 && ready) begin
                delivered.push_back(m_q[0][63:32]);
                void'(m_q.pop_front());
            end
            if (!m_halted && m_q.size() < 2) begin
                w = mem[m_pc[7:2]];
                if (w == 32'h0) begin
                    m_halted = 1'b1;
                end else begin
                    m_q.push_back({m_pc, w});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    // Called at a falling edge: drive inputs, check, advance one clock.
    task automatic apply_stimulus(input logic ready, input logic redir,
                                  input logic [31:0] rpc, input string where);
        bus.i_ready       = ready;
        bus.i_redirect    = redir;
        bus.i_redirect_pc = rpc;
        check_state(where);
        model_step(ready, redir, rpc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        bus.i_ready       = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        $display("[TB] tb_ifetch start");
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_1013 + (i << 7);

        // Program runs to a zero word and halts.
        mem[0] = 32'h0000_00B3;
        mem[1] = 32'h0204_0293;
        mem[2] = 32'h0204_0293;
        mem[3] = 32'h0081_2023;
        mem[4] = 32'h0000_0000;
        do_reset();
        delivered.delete();
        for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 1'b0, 32'h0, "t1");
        check_output("t1 count", 32'(delivered.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_output($sformatf("t1 pc%0d", i),
                         (i < delivered.size()) ? delivered[i] : 32'hDEAD_BEEF, 32'(i * 4));
        check_output("t1 halted", {31'b0, bus.o_halted}, 32'd1);
        check_output("t1 valid", {31'b0, bus.o_valid}, 32'd0);

        // Backpressure: buffer fills, pc freezes, head stable.
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_1013 + (i << 7);
        do_reset();
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 32'h0, "t2 stall");
        check_output("t2 addr", bus.o_imem_addr, 32'd2);
        check_output("t2 head", bus.o_pc, 32'd0);
        delivered.delete();
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 32'h0, "t2 drain");
        check_output("t2 count", 32'(delivered.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check_output($sformatf("t2 pc%0d", i),
                         (i < delivered.size()) ? delivered[i] : 32'hDEAD_BEEF, 32'(i * 4));

        // Redirect while full: one bubble, then the target.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 32'h0, "t3 fill");
        apply_stimulus(1'b0, 1'b1, 32'h10, "t3 redirect");
        check_output("t3 bubble", {31'b0, bus.o_valid}, 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0, "t3 fetch");
        check_output("t3 target", bus.o_pc, 32'h10);

        // Halt at pc 0x20, then redirect out of HALT.
        mem[8] = 32'h0;
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 32'h0, "t4 run");
        check_output("t4 halted", {31'b0, bus.o_halted}, 32'd1);
        apply_stimulus(1'b1, 1'b1, 32'h4, "t4 redirect");
        check_output("t4 unhalt", {31'b0, bus.o_halted}, 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0, "t4 fetch");
        check_output("t4 target", bus.o_pc, 32'h4);

        // Misaligned redirect target.
        apply_stimulus(1'b1, 1'b1, 32'h6, "t5 redirect");
`ifdef IFETCH_MISALIGN_TRAP_EN
        check_output("t5 halted", {31'b0, bus.o_halted}, 32'd1);
        check_output("t5 mis", {31'b0, bus.o_misaligned}, 32'd1);
        apply_stimulus(1'b1, 1'b0, 32'h0, "t5 hold");
        check_output("t5 nofetch", {31'b0, bus.o_valid}, 32'd0);
        apply_stimulus(1'b1, 1'b1, 32'h0, "t5 realign");
        check_output("t5 mis clear", {31'b0, bus.o_misaligned}, 32'd0);
`else
        apply_stimulus(1'b1, 1'b0, 32'h0, "t5 fetch");
        check_output("t5 aligned", bus.o_pc, 32'h4);
`endif

        // pc wraps from the top of the address space.
        apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFFC, "t6 redirect");
        apply_stimulus(1'b1, 1'b0, 32'h0, "t6 top");
        check_output("t6 top pc", bus.o_pc, 32'hFFFF_FFFC);
        apply_stimulus(1'b1, 1'b0, 32'h0, "t6 wrap");
        check_output("t6 wrap pc", bus.o_pc, 32'h0);

        // Asynchronous reset mid-stream clears outputs with no clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_output("t6 async valid", {31'b0, bus.o_valid}, 32'd0);
        check_output("t6 async addr", bus.o_imem_addr, RESET_PC >> 2);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the model.
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 19) == 0) ? 32'h0 : ($urandom | 32'h1);
        mem[0] = 32'h0000_0013;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        ready;
            logic        redir;
            logic [31:0] rpc;
            ready = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if (cyc == 200) begin
                #2 rst_n = 1'b0;
                #1;
                check_output("rand async valid", {31'b0, bus.o_valid}, 32'd0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            apply_stimulus(ready, redir, rpc, $sformatf("rand%0d", cyc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage: the initiator on the instruction-memory read port. Holds the program counter and drives a word address to the combinational `imem` every cycle. Captures `{pc, instr}` pairs into a 2-entry buffer and hands them to decode over a valid/ready handshake. Accepts branch/jump redirects from execute and halts on an all-zero instruction word.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset; bits [1:0] must be 0.
- `i_clk` input 1: single clock, all state on rising edge.
- `i_rst_n` input 1: reset, asynchronous, active-low. One clock, reset asynchronous and active-low.
- `o_imem_addr` output 32: word index to `imem`, equal to `{2'b00, pc[31:2]}`.
- `i_imem_data` input 32: instruction word from `imem`, valid combinationally in the same cycle.
- `o_valid` output 1: buffer head holds an instruction.
- `i_ready` input 1: decode accepts the head this cycle.
- `o_instr` output 32: head instruction; 0 when `o_valid`=0.
- `o_pc` output 32: byte PC of head instruction; 0 when `o_valid`=0.
- `i_redirect` input 1: one-cycle pulse from execute carrying a taken branch or jump.
- `i_redirect_pc` input 32: redirect target byte address.
- `o_halted` output 1: fetch is in HALT.
- `o_misaligned` output 1: HALT was entered on a misaligned redirect (only with `IFETCH_MISALIGN_TRAP_EN`).

## Operation
- State machine: RUN, HALT.
  - Reset values: state RUN, pc=`RESET_PC`, buffer count 0, `o_valid`/`o_halted`/`o_misaligned` = 0.
- Fetch condition: state RUN, no redirect, and buffer has space (count<2, or count==2 with pop this cycle).
- On fetch with `i_imem_data`≠0: push `{pc, i_imem_data}` and set pc ← pc+4.
  - pc wraps modulo 2^32: 32'hFFFF_FFFC → 32'h0.
- On fetch with `i_imem_data`==0: nothing is pushed, pc holds, state goes to HALT, `o_halted` goes to 1.
  - Entries already buffered still drain to decode.
- Pop: `o_valid && i_ready`. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority, accepted in any state):
  - Buffer cleared and pc ← `i_redirect_pc`.
  - State goes to RUN; `o_halted` and `o_misaligned` clear.
  - No push that cycle.
  - A handshake occurring in the same cycle counts as delivered; squashing it is the hazard unit's job.
- With no redirect, HALT is sticky.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous); any buffered entries are lost.

## Timing
- `o_imem_addr` is combinational from the pc register.
- Redirect on edge N: the target instruction is presented with `o_valid`=1 after edge N+1. This gives one bubble cycle.
- Steady state with `i_ready`=1: one instruction per cycle, `o_pc` incrementing by 4.
- Reset release: first instruction (pc=`RESET_PC`) is valid after the first rising edge with `i_rst_n`=1.
- Backpressure: with `i_ready`=0, the buffer fills within 2 cycles. The head is then held stable (`o_instr`, `o_pc` unchanged) and the pc freezes.
- HALT: `o_halted` rises after the edge that sampled the zero word.

## Configuration
- `IFETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `i_redirect_pc[1:0]`≠0 clears the buffer, loads pc with the target unchanged, enters HALT, and sets `o_misaligned`=1.
  - `o_misaligned` clears on the next aligned redirect or on reset.
- `IFETCH_MISALIGN_TRAP_EN` undefined:
  - `i_redirect_pc[1:0]` is forced to 0 on load.
  - `o_misaligned` is tied to 0.

## Structure
- Package `ifetch_pkg` holds:
  - the state enum (`FETCH_RUN`, `FETCH_HALT`);
  - `INSTR_W`=32, `XLEN`=32;
  - the halt-word constant 32'h0;
  - `PC_STEP`=4.
- Sub-module `ifetch_fifo`: 2-entry, 64-bit-wide synchronous FIFO with push, pop, clear, count, and a head output that is zero when empty.
- The top level holds the pc register, state machine, and redirect/alignment logic.

## Test plan
- Reset with `RESET_PC`=0, memory words 0x000000B3, 0x02040293, 0x02040293, 0x00812023, then 0; `i_ready`=1 → four instructions delivered with `o_pc` 0, 4, 8, 12, then `o_halted`=1 and `o_valid`=0.
- `i_ready`=0 for 5 cycles after reset → count saturates at 2, `o_imem_addr` stays at 2, head stays `o_pc`=0. Releasing `i_ready` delivers 0, 4, 8 in consecutive cycles.
- Redirect to 0x10 while the buffer is full → next cycle `o_valid`=0, following cycle `o_pc`=0x10.
- In HALT, redirect to 0x4 → `o_halted` clears, instruction at pc 0x4 delivered two edges later.
- Redirect to 0x6: with `IFETCH_MISALIGN_TRAP_EN`, `o_halted`=`o_misaligned`=1 and no fetch; without it, fetch resumes at `o_pc`=0x4.
- Redirect to 32'hFFFF_FFFC with a nonzero word → next fetched `o_pc`=0; reset asserted mid-stream → `o_valid`=0 with no clock edge required.
